// File: rtl/matrix_op_dispatcher.sv
// Matrix operation dispatcher: accepts one request, reads operand dimensions from
// the metadata store, validates them, then issues one compute command or one error pulse.
module matrix_op_dispatcher #(
  parameter int ID_WIDTH     = 3,
  parameter int DIM_WIDTH    = 4,
  parameter int MAX_DIM      = 8,
  parameter int SCALAR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [ID_WIDTH-1:0]     req_id_a,
  input  logic [ID_WIDTH-1:0]     req_id_b,
  input  logic [SCALAR_WIDTH-1:0] req_scalar,
  input  logic                    abort,
  output logic                    meta_rd_en,
  output logic [ID_WIDTH-1:0]     meta_rd_id,
  input  logic                    meta_rd_used,
  input  logic [DIM_WIDTH-1:0]    meta_rd_rows,
  input  logic [DIM_WIDTH-1:0]    meta_rd_cols,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [2:0]              cmd_op,
  output logic [ID_WIDTH-1:0]     cmd_id_a,
  output logic [ID_WIDTH-1:0]     cmd_id_b,
  output logic [SCALAR_WIDTH-1:0] cmd_scalar,
  output logic [DIM_WIDTH-1:0]    cmd_rows,
  output logic [DIM_WIDTH-1:0]    cmd_cols,
  output logic [DIM_WIDTH-1:0]    cmd_inner,
  output logic                    err_valid,
  output logic [2:0]              err_code,
  output logic                    busy
);

  localparam logic [2:0] OP_TRANSPOSE = 3'd0;
  localparam logic [2:0] OP_ADD       = 3'd1;
  localparam logic [2:0] OP_MUL       = 3'd2;
  localparam logic [2:0] OP_SMUL      = 3'd3;
  localparam logic [2:0] OP_SUB       = 3'd4;
  localparam logic [DIM_WIDTH-1:0] MAX_D = DIM_WIDTH'(MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP_A, S_CAPTURE_A, S_LOOKUP_B, S_CAPTURE_B, S_VALIDATE, S_ISSUE, S_ERROR
  } state_t;

  state_t                  state;
  logic [2:0]              op;
  logic [ID_WIDTH-1:0]     id_a, id_b;
  logic [SCALAR_WIDTH-1:0] scalar;
  logic                    used_a, used_b;
  logic [DIM_WIDTH-1:0]    rows_a, cols_a, rows_b, cols_b;

  logic                    binary, bad_a, bad_b;
  logic [2:0]              vcode;
  logic [DIM_WIDTH-1:0]    res_rows, res_cols, res_inner;

  // Validation and result shape are derived from the captured metadata so the
  // VALIDATE cycle only has to register them.
  always_comb begin
    binary    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    bad_a     = (rows_a == '0) || (cols_a == '0) || (rows_a > MAX_D) || (cols_a > MAX_D);
    bad_b     = (rows_b == '0) || (cols_b == '0) || (rows_b > MAX_D) || (cols_b > MAX_D);
    vcode     = 3'd0;
    if (!used_a)                vcode = 3'd2;
    else if (bad_a)             vcode = 3'd3;
    else if (binary && !used_b) vcode = 3'd4;
    else if (binary && bad_b)   vcode = 3'd5;
    else if ((op == OP_ADD || op == OP_SUB) && (rows_a != rows_b || cols_a != cols_b))
      vcode = 3'd6;
    else if (op == OP_MUL && cols_a != rows_b)
      vcode = 3'd6;

    res_rows  = rows_a;
    res_cols  = cols_a;
    res_inner = '0;
    if (op == OP_TRANSPOSE) begin
      res_rows = cols_a;
      res_cols = rows_a;
    end else if (op == OP_MUL) begin
      res_cols  = cols_b;
      res_inner = cols_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= '0;
      id_a       <= '0;
      id_b       <= '0;
      scalar     <= '0;
      used_a     <= 1'b0;
      used_b     <= 1'b0;
      rows_a     <= '0;
      cols_a     <= '0;
      rows_b     <= '0;
      cols_b     <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      meta_rd_en <= 1'b0;
      meta_rd_id <= '0;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_id_a   <= '0;
      cmd_id_b   <= '0;
      cmd_scalar <= '0;
      cmd_rows   <= '0;
      cmd_cols   <= '0;
      cmd_inner  <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
    end else begin
      meta_rd_en <= 1'b0;
      meta_rd_id <= '0;
      err_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op        <= req_op;
            id_a      <= req_id_a;
            id_b      <= req_id_b;
            scalar    <= req_scalar;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_op > OP_SUB) begin
              err_code  <= 3'd1;
              err_valid <= 1'b1;
              state     <= S_ERROR;
            end else begin
              meta_rd_en <= 1'b1;
              meta_rd_id <= req_id_a;
              state      <= S_LOOKUP_A;
            end
          end
        end
        S_LOOKUP_A: begin
          if (abort) begin
            state <= S_IDLE; req_ready <= 1'b1; busy <= 1'b0;
          end else state <= S_CAPTURE_A;
        end
        S_CAPTURE_A: begin
          used_a <= meta_rd_used;
          rows_a <= meta_rd_rows;
          cols_a <= meta_rd_cols;
          if (abort) begin
            state <= S_IDLE; req_ready <= 1'b1; busy <= 1'b0;
          end else if (binary) begin
            meta_rd_en <= 1'b1;
            meta_rd_id <= id_b;
            state      <= S_LOOKUP_B;
          end else state <= S_VALIDATE;
        end
        S_LOOKUP_B: begin
          if (abort) begin
            state <= S_IDLE; req_ready <= 1'b1; busy <= 1'b0;
          end else state <= S_CAPTURE_B;
        end
        S_CAPTURE_B: begin
          used_b <= meta_rd_used;
          rows_b <= meta_rd_rows;
          cols_b <= meta_rd_cols;
          if (abort) begin
            state <= S_IDLE; req_ready <= 1'b1; busy <= 1'b0;
          end else state <= S_VALIDATE;
        end
        S_VALIDATE: begin
          if (abort) begin
            state <= S_IDLE; req_ready <= 1'b1; busy <= 1'b0;
          end else if (vcode != 3'd0) begin
            err_code  <= vcode;
            err_valid <= 1'b1;
            state     <= S_ERROR;
          end else begin
            cmd_valid  <= 1'b1;
            cmd_op     <= op;
            cmd_id_a   <= id_a;
            cmd_id_b   <= binary ? id_b : '0;
            cmd_scalar <= (op == OP_SMUL) ? scalar : '0;
            cmd_rows   <= res_rows;
            cmd_cols   <= res_cols;
            cmd_inner  <= res_inner;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // abort is deliberately ignored here: a presented command is never withdrawn
          if (cmd_ready) begin
            cmd_valid  <= 1'b0;
            cmd_op     <= '0;
            cmd_id_a   <= '0;
            cmd_id_b   <= '0;
            cmd_scalar <= '0;
            cmd_rows   <= '0;
            cmd_cols   <= '0;
            cmd_inner  <= '0;
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        S_ERROR: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// Directed bench for matrix_op_dispatcher with a one-cycle-latency metadata store model.
module tb_matrix_op_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [2:0]  req_id_a = '0, req_id_b = '0;
  logic [31:0] req_scalar = '0;
  logic        abort = 1'b0;
  logic        meta_rd_en;
  logic [2:0]  meta_rd_id;
  logic        meta_rd_used = 1'b0;
  logic [3:0]  meta_rd_rows = '0, meta_rd_cols = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_id_a, cmd_id_b;
  logic [31:0] cmd_scalar;
  logic [3:0]  cmd_rows, cmd_cols, cmd_inner;
  logic        err_valid;
  logic [2:0]  err_code;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int meta_cnt = 0;

  logic       m_used [8];
  logic [3:0] m_rows [8];
  logic [3:0] m_cols [8];

  matrix_op_dispatcher #(.ID_WIDTH(3), .DIM_WIDTH(4), .MAX_DIM(8), .SCALAR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_id_a(req_id_a), .req_id_b(req_id_b), .req_scalar(req_scalar),
    .abort(abort),
    .meta_rd_en(meta_rd_en), .meta_rd_id(meta_rd_id), .meta_rd_used(meta_rd_used),
    .meta_rd_rows(meta_rd_rows), .meta_rd_cols(meta_rd_cols),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_id_a(cmd_id_a), .cmd_id_b(cmd_id_b), .cmd_scalar(cmd_scalar),
    .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_inner(cmd_inner),
    .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Metadata store: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (meta_rd_en) begin
      meta_rd_used <= m_used[meta_rd_id];
      meta_rd_rows <= m_rows[meta_rd_id];
      meta_rd_cols <= m_cols[meta_rd_id];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request in the current (IDLE) cycle; returns in cycle 1.
  task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic [31:0] s);
    chk("req_ready_before_accept", req_ready, 1);
    req_op = op; req_id_a = a; req_id_b = b; req_scalar = s;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    m_used = '{1, 1, 1, 1, 1, 1, 1, 0};
    m_rows = '{3, 2, 3, 1, 4, 2, 9, 0};
    m_cols = '{5, 3, 4, 8, 4, 2, 1, 0};

    steps(2);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_meta_rd_en", meta_rd_en, 0);

    // MUL 2x3 * 3x4 with a 5-cycle stall
    cmd_ready = 1'b0;
    send(3'd2, 3'd1, 3'd2, 32'h55);
    chk("mul_c1_meta_en", meta_rd_en, 1);
    chk("mul_c1_meta_id", meta_rd_id, 1);
    chk("mul_c1_busy", busy, 1);
    step();
    chk("mul_c2_meta_en", meta_rd_en, 0);
    step();
    chk("mul_c3_meta_en", meta_rd_en, 1);
    chk("mul_c3_meta_id", meta_rd_id, 2);
    steps(2);
    chk("mul_c5_cmd_valid", cmd_valid, 0);
    step();
    chk("mul_c6_cmd_valid", cmd_valid, 1);
    chk("mul_rows", cmd_rows, 2);
    chk("mul_cols", cmd_cols, 4);
    chk("mul_inner", cmd_inner, 3);
    chk("mul_op", cmd_op, 2);
    chk("mul_id_a", cmd_id_a, 1);
    chk("mul_id_b", cmd_id_b, 2);
    chk("mul_scalar", cmd_scalar, 0);
    chk("mul_req_ready", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mul_stall_valid", cmd_valid, 1);
      chk("mul_stall_cols", cmd_cols, 4);
      chk("mul_stall_req_ready", req_ready, 0);
    end
    cmd_ready = 1'b1;
    step();
    chk("mul_done_cmd_valid", cmd_valid, 0);
    chk("mul_done_req_ready", req_ready, 1);
    chk("mul_done_busy", busy, 0);

    // TRANSPOSE 3x5, B ignored, scalar suppressed
    meta_cnt = 0;
    send(3'd0, 3'd0, 3'd5, 32'h1234);
    for (int i = 1; i <= 4; i++) begin
      if (meta_rd_en) meta_cnt++;
      if (i == 3) chk("tr_c3_cmd_valid", cmd_valid, 0);
      if (i < 4) step();
    end
    chk("tr_meta_count", meta_cnt, 1);
    chk("tr_c4_cmd_valid", cmd_valid, 1);
    chk("tr_rows", cmd_rows, 5);
    chk("tr_cols", cmd_cols, 3);
    chk("tr_id_b", cmd_id_b, 0);
    chk("tr_scalar", cmd_scalar, 0);
    chk("tr_inner", cmd_inner, 0);
    step();
    chk("tr_idle", req_ready, 1);

    // ADD mismatch 2x2 + 2x3
    send(3'd1, 3'd5, 3'd1, 32'h0);
    steps(4);
    chk("addmm_c5_err", err_valid, 0);
    step();
    chk("addmm_c6_err", err_valid, 1);
    chk("addmm_code", err_code, 6);
    chk("addmm_cmd", cmd_valid, 0);
    step();
    chk("addmm_c7_err", err_valid, 0);
    chk("addmm_code_held", err_code, 6);
    chk("addmm_ready", req_ready, 1);

    // SUB of slot 4 with itself
    send(3'd4, 3'd4, 3'd4, 32'h0);
    steps(5);
    chk("sub_cmd_valid", cmd_valid, 1);
    chk("sub_rows", cmd_rows, 4);
    chk("sub_cols", cmd_cols, 4);
    chk("sub_op", cmd_op, 4);
    chk("sub_id_b", cmd_id_b, 4);
    step();

    // Illegal op 6
    send(3'd6, 3'd1, 3'd2, 32'h0);
    chk("ill_err", err_valid, 1);
    chk("ill_code", err_code, 1);
    chk("ill_meta_en", meta_rd_en, 0);
    step();
    chk("ill_ready", req_ready, 1);
    chk("ill_err_low", err_valid, 0);

    // A unused
    send(3'd0, 3'd7, 3'd0, 32'h0);
    steps(3);
    chk("aunused_err", err_valid, 1);
    chk("aunused_code", err_code, 2);
    step();

    // A = 9x1
    send(3'd3, 3'd6, 3'd0, 32'h1);
    steps(3);
    chk("abig_err", err_valid, 1);
    chk("abig_code", err_code, 3);
    step();

    // B unused
    send(3'd1, 3'd1, 3'd7, 32'h0);
    steps(5);
    chk("bunused_err", err_valid, 1);
    chk("bunused_code", err_code, 4);
    chk("bunused_cmd", cmd_valid, 0);
    step();

    // SCALAR_MUL with all-ones scalar
    send(3'd3, 3'd3, 3'd2, 32'hFFFF_FFFF);
    steps(3);
    chk("smul_cmd_valid", cmd_valid, 1);
    chk("smul_scalar", cmd_scalar, 32'hFFFF_FFFF);
    chk("smul_rows", cmd_rows, 1);
    chk("smul_cols", cmd_cols, 8);
    chk("smul_id_b", cmd_id_b, 0);
    step();

    // Abort in cycle 3 of a binary request
    send(3'd2, 3'd1, 3'd2, 32'h0);
    steps(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_cmd", cmd_valid, 0);
    chk("abort_err", err_valid, 0);
    send(3'd0, 3'd0, 3'd0, 32'h0);
    steps(3);
    chk("after_abort_cmd", cmd_valid, 1);
    chk("after_abort_rows", cmd_rows, 5);
    step();

    // Abort during ISSUE is ignored
    cmd_ready = 1'b0;
    send(3'd2, 3'd1, 3'd2, 32'h0);
    steps(5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("issue_abort_valid", cmd_valid, 1);
    chk("issue_abort_rows", cmd_rows, 2);
    chk("issue_abort_busy", busy, 1);
    cmd_ready = 1'b1;
    step();
    chk("issue_abort_done", cmd_valid, 0);
    send(3'd4, 3'd4, 3'd4, 32'h0);
    steps(5);
    chk("after_issue_abort_cmd", cmd_valid, 1);
    chk("after_issue_abort_rows", cmd_rows, 4);
    step();

    // Reset while stalled in ISSUE
    cmd_ready = 1'b0;
    send(3'd2, 3'd1, 3'd2, 32'h0);
    steps(5);
    chk("prerst_cmd_valid", cmd_valid, 1);
    chk("prerst_err_code", err_code, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmd_ready = 1'b1;
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_err_code", err_code, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
